div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Multi-cycle sequencer for the 32-bit DIV/DIVU datapath.
- Accepts an operation from EX, runs a radix-2 restoring divide over 32 iterations, and holds a pipeline stall request to the stall controller while busy.
- Returns {remainder, quotient} for the HI/LO write that travels down MEM/WB on the hi/lo side bus.
- Supports cancellation by pipeline flush.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- div_start  input  1  EX requests a divide; held high by EX while stalled.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE.
- div_opdata1  input  DATA_W  dividend (rs); sampled in IDLE.
- div_opdata2  input  DATA_W  divisor (rt); sampled in IDLE.
- annul  input  1  flush; cancels an in-flight divide.
- stallreq_for_div  output  1  stall request to the stall controller.
- div_ready  output  1  result valid.
- div_result  output  2*DATA_W  {remainder -> HI, quotient -> LO}.
- div_by_zero  output  1  divisor was zero for the current result.

Behaviour:
- States: IDLE, DIVZERO, BUSY, END; all registered.
- Reset (rst=1 at posedge):
  - state = IDLE, counter = 0.
  - div_ready = 0, div_result = 0, div_by_zero = 0.
  - Reset takes priority over every other condition, including mid-BUSY.
- IDLE, div_start=1 and annul=0:
  - If div_opdata2 == 0: go to DIVZERO.
  - Otherwise: latch absolute values (signed mode) or raw values, latch sign info, clear counter, go to BUSY.
  - With div_start=0, stay in IDLE.
- DIVZERO:
  - div_result = 0, div_by_zero = 1; go to END next cycle.
  - annul=1 returns to IDLE instead.
- BUSY, one iteration per cycle:
  - Shift {rem, quo} left by 1.
  - If rem_hi >= divisor: subtract divisor and set quotient bit 0.
  - Counter increments each iteration.
  - After iteration DATA_W-1, apply sign fix-up:
    - quotient is negated when signed and the operand signs differ;
    - remainder takes the dividend's sign.
  - Load div_result, set div_by_zero = 0, go to END.
  - annul=1 in any BUSY cycle goes to IDLE next cycle; no result is produced and div_result keeps its old value.
- END:
  - div_ready = 1; div_result is held stable.
  - If div_start=0, go to IDLE next cycle with div_ready cleared.
  - If div_start stays 1, remain in END; no restart without div_start first dropping.
  - annul=1 goes to IDLE.
- stallreq_for_div (combinational) = (state==IDLE & div_start & ~annul) | state==BUSY | state==DIVZERO. It is 0 in END so EX/MEM can capture the result.
- Latency for a nonzero divisor (cycle 0 = IDLE cycle with div_start sampled):
  - BUSY occupies cycles 1..32.
  - div_ready is high from cycle 33.
  - stallreq_for_div is high in cycles 0..32.
- Latency for a zero divisor: DIVZERO in cycle 1, div_ready high from cycle 2.
- Arithmetic:
  - Internal partial remainder is DATA_W+1 bits.
  - Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap, no trap).
- Back-to-back divides need at least one IDLE cycle between operations.

Test Plan:
- DIVU 100 / 7:
  - stallreq high cycles 0..32;
  - div_ready=1 at cycle 33;
  - div_result = {0x00000002, 0x0000000E}.
- DIV -7 / 2:
  - div_result = {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV 7 / -2:
  - div_result = {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF:
  - div_result = {0x00000000, 0x80000000}; div_by_zero=0.
- DIVU 5 / 0:
  - DIVZERO at cycle 1;
  - div_ready=1 and div_by_zero=1 at cycle 2;
  - div_result = 0; stallreq high only cycles 0..1.
- Cancel and reset mid-operation:
  - annul asserted at cycle 10: IDLE at cycle 11, stallreq=0, div_ready never asserts, prior div_result unchanged.
  - rst at cycle 20 of a separate divide: all outputs 0 the next cycle.
  - Hold div_start high in END for 3 cycles: div_result stable, no restart.
  - Drop div_start: IDLE next cycle.

Source files
------------

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. It stalls the pipeline while
// busy and returns {remainder, quotient} for the HI/LO write.
module div_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_W-1:0]     div_opdata1,
  input  logic [DATA_W-1:0]     div_opdata2,
  input  logic                  annul,
  output logic                  stallreq_for_div,
  output logic                  div_ready,
  output logic [2*DATA_W-1:0]   div_result,
  output logic                  div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_BUSY, S_END} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     rem_q;
  logic [DATA_W-1:0]     quo_q;
  logic [DATA_W-1:0]     dvsr_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic                  ready_q;
  logic [2*DATA_W-1:0]   result_q;
  logic                  dbz_q;

  logic [DATA_W:0]       rem_sh;
  logic [DATA_W:0]       diff;
  logic [DATA_W-1:0]     rem_d;
  logic [DATA_W-1:0]     quo_d;
  logic                  op1_neg;
  logic                  op2_neg;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  assign op1_neg = div_signed & div_opdata1[DATA_W-1];
  assign op2_neg = div_signed & div_opdata2[DATA_W-1];

  // Borrow out of the (DATA_W+1)-bit trial subtraction means rem_sh < divisor.
  always_comb begin
    rem_sh = {rem_q, quo_q[DATA_W-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    quo_d  = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
    rem_d  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_start && !annul) begin
            if (div_opdata2 == '0) begin
              state_q <= S_DIVZERO;
            end else begin
              rem_q     <= '0;
              quo_q     <= cond_neg(div_opdata1, op1_neg);
              dvsr_q    <= cond_neg(div_opdata2, op2_neg);
              neg_quo_q <= op1_neg ^ op2_neg;
              neg_rem_q <= op1_neg;
              cnt_q     <= '0;
              state_q   <= S_BUSY;
            end
          end
        end
        S_DIVZERO: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= '0;
            dbz_q    <= 1'b1;
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_BUSY: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            // Last iteration: sign fix-up; the remainder follows the dividend's sign.
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              result_q <= {cond_neg(rem_d, neg_rem_q), cond_neg(quo_d, neg_quo_q)};
              dbz_q    <= 1'b0;
              ready_q  <= 1'b1;
              state_q  <= S_END;
            end
          end
        end
        S_END: begin
          if (annul || !div_start) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stallreq_for_div = (state_q == S_IDLE && div_start && !annul) ||
                            (state_q == S_BUSY) || (state_q == S_DIVZERO);
  assign div_ready   = ready_q;
  assign div_result  = result_q;
  assign div_by_zero = dbz_q;

endmodule
